// File: rtl/day3_pkg.sv
// Shared constants for the day3 edge detector slice.
package day3_pkg;

  localparam int unsigned WIDTH_DEF   = 1;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/day3_sync.sv
// Per-lane multi-flop synchronizer chain with synchronous active-high reset.
module day3_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (reset) stage_q[i] <= '0;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/day3_edge_detector.sv
// Multi-lane rising/falling edge detector with saturating edge counters.
// Define DAY3_SYNC_EN to insert a 2-flop input synchronizer per lane.
module day3_edge_detector
  import day3_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] rising_edge_o,
  output logic [WIDTH-1:0] falling_edge_o,
  output logic             any_edge_o,
  output logic [CNT_W-1:0] rise_cnt_o,
  output logic [CNT_W-1:0] fall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_d, prev_q;
  logic [CNT_W-1:0] rise_cnt_d, rise_cnt_q;
  logic [CNT_W-1:0] fall_cnt_d, fall_cnt_q;
  logic [WIDTH-1:0] rise, fall;

`ifdef DAY3_SYNC_EN
  day3_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (a_i),
    .q_o   (level)
  );
`else
  assign level = a_i;
`endif

  // Edge pulses are combinational off the live level; reset masks them in the same cycle.
  always_comb begin
    rise = '0;
    fall = '0;
    if (!reset) begin
      rise = level & ~prev_q;
      fall = ~level & prev_q;
    end
  end

  always_comb begin
    prev_d     = level;
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    if (cnt_clr_i) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
    end else begin
      if ((|rise) && (rise_cnt_q != '1)) rise_cnt_d = rise_cnt_q + CNT_ONE;
      if ((|fall) && (fall_cnt_q != '1)) fall_cnt_d = fall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign rising_edge_o  = rise;
  assign falling_edge_o = fall;
  assign any_edge_o     = (|rise) | (|fall);
  assign rise_cnt_o     = rise_cnt_q;
  assign fall_cnt_o     = fall_cnt_q;

endmodule

// File: tb/tb_day3_edge_detector.sv
// Scoreboard bench for day3_edge_detector: stimulus pushes expected outputs, a monitor pops and compares.
module tb_day3_edge_detector;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef DAY3_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  a_i = '0;
  logic          cnt_clr_i = 1'b0;
  logic [W-1:0]  rising_edge_o, falling_edge_o;
  logic          any_edge_o;
  logic [CW-1:0] rise_cnt_o, fall_cnt_o;

  always #5 clk = ~clk;

  day3_edge_detector #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .a_i            (a_i),
    .cnt_clr_i      (cnt_clr_i),
    .rising_edge_o  (rising_edge_o),
    .falling_edge_o (falling_edge_o),
    .any_edge_o     (any_edge_o),
    .rise_cnt_o     (rise_cnt_o),
    .fall_cnt_o     (fall_cnt_o)
  );

  typedef struct {
    logic [W-1:0]  r;
    logic [W-1:0]  f;
    logic          any;
    logic [CW-1:0] rc;
    logic [CW-1:0] fc;
    bit            chk_cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: sampled-input history (index k = value k clocks ago) plus integer counters.
  logic [W-1:0] hist [LAT+2];
  int           rc_m = 0;
  int           fc_m = 0;
  bit           cnt_known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [W-1:0] a, input logic clr, input logic rst);
    exp_t         e;
    logic [W-1:0] lvl, prv;
    @(posedge clk);
    #1;
    a_i       = a;
    cnt_clr_i = clr;
    reset     = rst;
    hist[0] = a;
    lvl = hist[LAT];
    prv = hist[LAT+1];
    e.r = '0;
    e.f = '0;
    for (int n = 0; n < W; n++) begin
      if (!rst && lvl[n] == 1'b1 && prv[n] == 1'b0) e.r[n] = 1'b1;
      if (!rst && lvl[n] == 1'b0 && prv[n] == 1'b1) e.f[n] = 1'b1;
    end
    e.any     = (e.r != '0) || (e.f != '0);
    e.rc      = CW'(rc_m);
    e.fc      = CW'(fc_m);
    e.chk_cnt = cnt_known;
    q.push_back(e);
    for (int k = LAT + 1; k >= 1; k--) hist[k] = rst ? '0 : hist[k-1];
    if (rst || clr) begin
      rc_m = 0;
      fc_m = 0;
    end else begin
      if (e.r != '0) rc_m = (rc_m < CMAX) ? rc_m + 1 : CMAX;
      if (e.f != '0) fc_m = (fc_m < CMAX) ? fc_m + 1 : CMAX;
    end
    if (rst) cnt_known = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rising_edge", 32'(rising_edge_o), 32'(e.r));
        chk("falling_edge", 32'(falling_edge_o), 32'(e.f));
        chk("any_edge", 32'(any_edge_o), 32'(e.any));
        if (e.chk_cnt) begin
          chk("rise_cnt", 32'(rise_cnt_o), 32'(e.rc));
          chk("fall_cnt", 32'(fall_cnt_o), 32'(e.fc));
        end
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] a, mask;
    int           guard;
    for (int k = 0; k < LAT + 2; k++) hist[k] = '0;

    // Reset held two clocks with input high, then release: one rising pulse.
    cyc(4'b0001, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b1);
    repeat (LAT + 2) cyc(4'b0001, 1'b0, 1'b0);
    // Level sequence 1,0,0,1 on lane 0.
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    repeat (LAT + 1) cyc(4'b0000, 1'b0, 1'b0);
    // Multi-lane rise counts once.
    cyc(4'b0101, 1'b0, 1'b0);
    repeat (LAT + 2) cyc(4'b0101, 1'b0, 1'b0);
    // Saturation, then clear colliding with a further edge.
    cyc(4'b0000, 1'b1, 1'b0);
    repeat (CMAX + 2) begin
      cyc(4'b0001, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
    end
    repeat (LAT) cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    repeat (LAT + 2) cyc(4'b0001, 1'b0, 1'b0);
    // Reset asserted in the cycle the input rises.
    cyc(4'b0000, 1'b0, 1'b0);
    repeat (LAT + 1) cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1);
    repeat (LAT + 2) cyc(4'b0010, 1'b0, 1'b0);

    a = 4'b0010;
    repeat (600) begin
      for (int n = 0; n < W; n++) mask[n] = ($urandom_range(2) == 0);
      a = a ^ mask;
      cyc(a, ($urandom_range(9) == 0), ($urandom_range(49) == 0));
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
